// File: rtl/pdm_mic_emulator.sv
`timescale 1ns/1ps
// pdm_mic_emulator: PCM stream -> sample FIFO -> first-order sigma-delta PDM.
// Ticks are derived from a pdm_clk_i strobe that lives in the clk_i domain.
module pdm_mic_emulator #(
  parameter int SAMPLE_W   = 16,
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            en_i,
  input  logic [SAMPLE_W-1:0]             pcm_data_i,
  input  logic                            pcm_valid_i,
  output logic                            pcm_ready_o,
  input  logic                            pdm_clk_i,
  output logic                            pdm_data_o,
  output logic                            underflow_o,
  input  logic                            underflow_clr_i,
  output logic [$clog2(FIFO_DEPTH):0]     level_o
);

  localparam int ACC_W = SAMPLE_W + 2;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CW    = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [LVL_W-1:0]        DEPTH_L = LVL_W'(FIFO_DEPTH);
  localparam logic [CW-1:0]           CNT_MAX = CW'(OSR - 1);
  localparam logic signed [ACC_W-1:0] FS      = {2'b00, 1'b1, {(SAMPLE_W-1){1'b0}}};

  // Sign-extend a PCM sample to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext(input logic signed [SAMPLE_W-1:0] s);
    return {{2{s[SAMPLE_W-1]}}, s};
  endfunction

  // One sigma-delta step: integrate the input and subtract the fed-back +/-FS.
  function automatic logic signed [ACC_W-1:0] sd_step(input logic signed [ACC_W-1:0] acc,
                                                      input logic signed [ACC_W-1:0] x,
                                                      input logic                    y);
    return acc + x + (y ? -FS : FS);
  endfunction

  logic                         pdm_clk_q, pdm_clk_d;
  logic                         tick_q, tick_d;
  logic [CW-1:0]                tick_cnt_q, tick_cnt_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic signed [SAMPLE_W-1:0]   cur_sample_q, cur_sample_d;
  logic                         pdm_data_q, pdm_data_d;
  logic                         underflow_q, underflow_d;
  logic [LVL_W-1:0]             level_q, level_d;
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
  logic signed [SAMPLE_W-1:0]   mem_q [FIFO_DEPTH];
  logic signed [SAMPLE_W-1:0]   mem_d [FIFO_DEPTH];

  logic                         push, tick, load, pop, uf_set, y;
  logic signed [SAMPLE_W-1:0]   head;
  logic signed [ACC_W-1:0]      x;

  assign pcm_ready_o = (level_q < DEPTH_L);
  assign pdm_data_o  = pdm_data_q;
  assign underflow_o = underflow_q;
  assign level_o     = level_q;

  // Next-state logic: edge detect, FIFO bookkeeping, modulator and sticky flag.
  always_comb begin
    pdm_clk_d    = pdm_clk_i;
    tick_d       = pdm_clk_i & ~pdm_clk_q;
    tick_cnt_d   = tick_cnt_q;
    acc_d        = acc_q;
    cur_sample_d = cur_sample_q;
    pdm_data_d   = pdm_data_q;
    underflow_d  = underflow_q;
    level_d      = level_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_d        = mem_q;

    push   = pcm_valid_i & pcm_ready_o;
    tick   = tick_q & en_i;
    load   = tick & (tick_cnt_q == '0);
    pop    = load & (level_q != '0);
    uf_set = load & (level_q == '0);
    head   = mem_q[rd_ptr_q];
    y      = ~acc_q[ACC_W-1];

    // A load with an empty FIFO feeds silence rather than stale data.
    if (load) x = pop ? sext(head) : '0;
    else      x = sext(cur_sample_q);

    if (!en_i) begin
      acc_d      = '0;
      tick_cnt_d = '0;
      pdm_data_d = 1'b0;
    end else if (tick) begin
      pdm_data_d = y;
      acc_d      = sd_step(acc_q, x, y);
      tick_cnt_d = (tick_cnt_q == CNT_MAX) ? '0 : tick_cnt_q + CW'(1);
      if (load) cur_sample_d = pop ? head : '0;
    end

    if (underflow_clr_i) underflow_d = 1'b0;
    else if (uf_set)     underflow_d = 1'b1;

    if (push) begin
      mem_d[wr_ptr_q] = pcm_data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers; reset clears everything, including FIFO storage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pdm_clk_q    <= 1'b0;
      tick_q       <= 1'b0;
      tick_cnt_q   <= '0;
      acc_q        <= '0;
      cur_sample_q <= '0;
      pdm_data_q   <= 1'b0;
      underflow_q  <= 1'b0;
      level_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pdm_clk_q    <= pdm_clk_d;
      tick_q       <= tick_d;
      tick_cnt_q   <= tick_cnt_d;
      acc_q        <= acc_d;
      cur_sample_q <= cur_sample_d;
      pdm_data_q   <= pdm_data_d;
      underflow_q  <= underflow_d;
      level_q      <= level_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
    end
  end

endmodule

// File: tb/tb_pdm_mic_emulator.sv
`timescale 1ns/1ps
// Directed bench for pdm_mic_emulator (SAMPLE_W=16, OSR=64, FIFO_DEPTH=4).
module tb_pdm_mic_emulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] pcm_data = '0;
  logic        pcm_valid = 1'b0;
  logic        pcm_ready;
  logic        pdm_clk = 1'b0;
  logic        pdm_data;
  logic        underflow;
  logic        uf_clr = 1'b0;
  logic [2:0]  level;

  int n_cmp = 0;
  int n_err = 0;

  pdm_mic_emulator #(.SAMPLE_W(16), .OSR(64), .FIFO_DEPTH(4)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .en_i            (en),
    .pcm_data_i      (pcm_data),
    .pcm_valid_i     (pcm_valid),
    .pcm_ready_o     (pcm_ready),
    .pdm_clk_i       (pdm_clk),
    .pdm_data_o      (pdm_data),
    .underflow_o     (underflow),
    .underflow_clr_i (uf_clr),
    .level_o         (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push_sample(input logic [15:0] v);
    pcm_data  = v;
    pcm_valid = 1'b1;
    cyc();
    pcm_valid = 1'b0;
  endtask

  // One pdm_clk period (2 high, 2 low); returns the bit produced by its tick.
  task automatic pulse(output logic b);
    pdm_clk = 1'b1;
    cyc();
    cyc();
    b = pdm_data;
    pdm_clk = 1'b0;
    cyc();
    cyc();
  endtask

  logic b, b0, b1;
  int   ones;
  int   pushed;

  initial begin
    // Reset state
    #2;
    chk("rst_pdm", pdm_data, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", pcm_ready, 1);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_ready", pcm_ready, 1);

    // Zero input: alternating 1,0 with a two-cycle registered latency
    push_sample(16'd0);
    chk("zero_level", level, 1);
    en = 1'b1;
    pdm_clk = 1'b1;
    cyc();
    chk("lat_not_yet", pdm_data, 0);
    cyc();
    chk("lat_updated", pdm_data, 1);
    pdm_clk = 1'b0;
    cyc(); cyc();
    for (int i = 1; i < 16; i++) begin
      pulse(b);
      chk($sformatf("zero_bit%0d", i), b, (i % 2 == 0) ? 1 : 0);
    end
    chk("zero_uf", underflow, 0);
    en = 1'b0;
    cyc();

    // Full scale positive
    push_sample(16'sd32767);
    en = 1'b1;
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      pulse(b);
      if (i == 0) b0 = b;
      if (i == 1) b1 = b;
      ones += b;
    end
    chk("fsp_ones", ones, 63);
    chk("fsp_first", b0, 1);
    chk("fsp_second", b1, 0);
    en = 1'b0;
    cyc();

    // Full scale negative
    push_sample(16'h8000);
    en = 1'b1;
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      pulse(b);
      if (i == 0) b0 = b;
      ones += b;
    end
    chk("fsn_ones", ones, 1);
    chk("fsn_first", b0, 1);
    en = 1'b0;
    cyc();

    // Half scale over 8 samples, FIFO topped up as it drains
    pushed = 0;
    for (int i = 0; i < 4; i++) begin
      push_sample(16'sd16384);
      pushed++;
    end
    en = 1'b1;
    ones = 0;
    for (int t = 0; t < 512; t++) begin
      if (pushed < 8 && level < 4) begin
        push_sample(16'sd16384);
        pushed++;
      end
      pulse(b);
      ones += b;
    end
    chk("half_ones_in_range", (ones >= 383 && ones <= 385), 1);
    chk("half_uf", underflow, 0);
    en = 1'b0;
    cyc();

    // Backpressure: 4 fill the FIFO, the 5th waits for a load tick
    for (int i = 0; i < 4; i++) push_sample(16'(100 + i));
    chk("bp_level_full", level, 4);
    chk("bp_ready_low", pcm_ready, 0);
    pcm_data  = 16'd200;
    pcm_valid = 1'b1;
    cyc(); cyc();
    chk("bp_held_level", level, 4);
    en = 1'b1;
    pdm_clk = 1'b1;
    cyc();
    chk("bp_pre_load", level, 4);
    cyc();
    chk("bp_after_pop", level, 3);
    chk("bp_ready_back", pcm_ready, 1);
    chk("bp_bit", pdm_data, 1);
    cyc();
    pcm_valid = 1'b0;
    chk("bp_accepted", level, 4);
    pdm_clk = 1'b0;
    cyc();

    // Disable mid-sample, then re-enable pops on the first tick
    pulse(b);
    chk("dis_bit1", b, 0);
    pulse(b);
    chk("dis_bit2", b, 1);
    en = 1'b0;
    cyc();
    chk("dis_pdm_low", pdm_data, 0);
    chk("dis_level_kept", level, 4);
    en = 1'b1;
    pulse(b);
    chk("reen_bit", b, 1);
    chk("reen_pop", level, 3);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #2;
    chk("arst_pdm", pdm_data, 0);
    chk("arst_level", level, 0);
    chk("arst_ready", pcm_ready, 1);
    chk("arst_uf", underflow, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Underflow on an empty FIFO, clear, and a push on the load cycle
    pulse(b);
    chk("uf_bit0", b, 1);
    chk("uf_set", underflow, 1);
    pulse(b);
    chk("uf_bit1", b, 0);
    uf_clr = 1'b1;
    cyc();
    uf_clr = 1'b0;
    chk("uf_cleared", underflow, 0);
    for (int i = 2; i < 64; i++) begin
      pulse(b);
      chk($sformatf("uf_zero_bit%0d", i), b, (i % 2 == 0) ? 1 : 0);
    end
    chk("uf_stays_clear", underflow, 0);
    pdm_clk = 1'b1;
    cyc();
    pcm_data  = 16'd7;
    pcm_valid = 1'b1;
    cyc();
    pcm_valid = 1'b0;
    chk("uf_load_push_flag", underflow, 1);
    chk("uf_load_push_level", level, 1);
    chk("uf_load_bit", pdm_data, 1);
    pdm_clk = 1'b0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
